// File: rtl/byte_unstripping_n_pkg.sv
// Shared defaults and helpers for the lane striping/unstriping family.
// Lane-index width helper is reused by the parametrised striper.
package byte_unstripping_n_pkg;

  localparam int unsigned DEF_LANES = 2;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // A single lane still needs a 1-bit index so the pointer never collapses to zero width.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/byte_unstripping_n_lane_fifo.sv
// Per-lane synchronous FIFO; head is visible combinationally, ready is registered
// from the post-update count so it depends on no input in the same cycle.
module lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_f,
  input  logic                     reset_L,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ready;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && !o_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CW'(DEPTH));
    end
  end

  // Storage carries no reset: contents are only observable behind a valid count.
  always_ff @(posedge clk_f) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_ready = r_ready;

endmodule

// File: rtl/byte_unstripping_n.sv
// N-lane unstripper: drains per-lane FIFOs strictly round-robin (lane 0 first)
// into one registered output word with valid/ready backpressure.
module byte_unstripping_n
  import byte_unstripping_n_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk_f,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] data_stripe,
  input  logic [LANES-1:0]       valid_stripe,
  output logic [LANES-1:0]       ready_stripe,
  output logic [WIDTH-1:0]       data_unstriped,
  output logic                   valid_unstriped,
  input  logic                   ready_unstriped,
  output logic [LANES-1:0]       overflow_err
);

  localparam int LW = lane_idx_w(LANES);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LW-1:0]    r_cur_lane;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [LANES-1:0] r_err;

  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_ready;
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_full;
  logic [CW-1:0]    w_count [LANES];
  logic [WIDTH-1:0] w_head  [LANES];
  logic             w_load;
  logic             w_unused_fifo_stat;

  // Never skip an empty lane: stalling on it is what keeps byte order intact.
  assign w_load = !w_empty[r_cur_lane] && (!r_valid || ready_unstriped);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_push[gi] = valid_stripe[gi] && w_ready[gi];
    assign w_pop[gi]  = w_load && (r_cur_lane == LW'(gi));

    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_f      (clk_f),
      .reset_L    (reset_L),
      .i_push     (w_push[gi]),
      .i_push_dat (data_stripe[gi*WIDTH +: WIDTH]),
      .i_pop      (w_pop[gi]),
      .o_head     (w_head[gi]),
      .o_full     (w_full[gi]),
      .o_empty    (w_empty[gi]),
      .o_count    (w_count[gi]),
      .o_ready    (w_ready[gi])
    );
  end

  always_comb begin
    w_unused_fifo_stat = ^w_full;
    for (int i = 0; i < LANES; i++) begin
      w_unused_fifo_stat = w_unused_fifo_stat ^ (^w_count[i]);
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      r_cur_lane <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= '0;
    end else begin
      r_err <= r_err | (valid_stripe & ~w_ready);
      if (w_load) begin
        r_data     <= w_head[r_cur_lane];
        r_valid    <= 1'b1;
        r_cur_lane <= (r_cur_lane == LW'(LANES - 1)) ? '0 : r_cur_lane + 1'b1;
      end else if (ready_unstriped) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ready_stripe    = w_ready;
  assign data_unstriped  = r_data;
  assign valid_unstriped = r_valid;
  assign overflow_err    = r_err;

endmodule

// File: tb/tb_byte_unstripping_n.sv
// Directed and randomized bench for the 4-lane unstripper against a per-lane queue model.
module tb_byte_unstripping_n;

  localparam int L = 4;
  localparam int W = 8;
  localparam int D = 4;

  logic           clk_f = 1'b0;
  logic           reset_L;
  logic [L*W-1:0] data_stripe;
  logic [L-1:0]   valid_stripe;
  logic [L-1:0]   ready_stripe;
  logic [W-1:0]   data_unstriped;
  logic           valid_unstriped;
  logic           ready_unstriped;
  logic [L-1:0]   overflow_err;

  byte_unstripping_n #(.LANES(L), .WIDTH(W), .DEPTH(D)) u_dut (
    .clk_f           (clk_f),
    .reset_L         (reset_L),
    .data_stripe     (data_stripe),
    .valid_stripe    (valid_stripe),
    .ready_stripe    (ready_stripe),
    .data_unstriped  (data_unstriped),
    .valid_unstriped (valid_unstriped),
    .ready_unstriped (ready_unstriped),
    .overflow_err    (overflow_err)
  );

  always #5 clk_f = ~clk_f;

  // Reference: the k-th output word is the (k/L)-th accepted word of lane k%L.
  logic [W-1:0] q [L][$];
  int           out_idx;
  logic [L-1:0] err_exp;
  int           acc [L];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < L; i++) q[i].delete();
    out_idx = 0;
    err_exp = '0;
  endtask

  // Called just after a negedge: samples pre-edge handshakes, crosses one posedge, checks, returns at negedge.
  task automatic tick();
    logic [L-1:0]   vs, rs;
    logic           vo, ro, rl;
    logic [W-1:0]   dout;
    logic [L*W-1:0] din;
    int             lane;
    vs = valid_stripe; rs = ready_stripe; vo = valid_unstriped; ro = ready_unstriped;
    dout = data_unstriped; din = data_stripe; rl = reset_L;
    @(posedge clk_f);
    #1;
    if (!rl) begin
      model_clear();
    end else begin
      if (vo && ro) begin
        lane = out_idx % L;
        checks++;
        assert (q[lane].size() > 0) else begin
          errors++;
          $error("FAIL out_unexpected: observed word %0h with lane %0d queue empty", dout, lane);
        end
        if (q[lane].size() > 0) chk("out_data", 32'(dout), 32'(q[lane].pop_front()));
        out_idx++;
      end
      for (int i = 0; i < L; i++) begin
        if (vs[i] && rs[i]) begin
          q[i].push_back(din[i*W +: W]);
          acc[i]++;
        end else if (vs[i]) begin
          err_exp[i] = 1'b1;
        end
      end
      if (vo && !ro) begin
        chk("hold_valid", 32'(valid_unstriped), 32'd1);
        chk("hold_data", 32'(data_unstriped), 32'(dout));
      end
    end
    chk("overflow_err", 32'(overflow_err), 32'(err_exp));
    @(negedge clk_f);
  endtask

  task automatic idle(input int n);
    valid_stripe = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [L-1:0] vm;
    int           pending;
    reset_L = 1'b0;
    valid_stripe = '1;
    data_stripe = $urandom;
    ready_unstriped = 1'b0;
    model_clear();
    for (int i = 0; i < L; i++) acc[i] = 0;
    @(negedge clk_f);

    // Reset held with valid asserted: everything reads zero, nothing is written.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(ready_stripe), 32'd0);
      chk("rst_valid", 32'(valid_unstriped), 32'd0);
      chk("rst_data", 32'(data_unstriped), 32'd0);
    end
    reset_L = 1'b1;
    valid_stripe = '0;
    tick();
    chk("ready_after_rst", 32'(ready_stripe), 32'(L'('1)));

    // Ordered merge, one word per lane on three consecutive edges.
    ready_unstriped = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_stripe = '1;
      for (int i = 0; i < L; i++) data_stripe[i*W +: W] = W'(8'hA0 + 4*k + i);
      tick();
      if (k == 0) chk("latency_empty", 32'(valid_unstriped), 32'd0);
      if (k == 1) begin
        chk("latency_valid", 32'(valid_unstriped), 32'd1);
        chk("latency_data", 32'(data_unstriped), 32'hA0);
      end
    end
    idle(14);
    chk("merge_count", 32'(out_idx), 32'd12);

    // Lane 1 silent: output stalls on it rather than skipping ahead.
    valid_stripe = 4'b1101;
    data_stripe = {8'h13, 8'h12, 8'h00, 8'h10};
    tick();
    valid_stripe = '0;
    tick();
    chk("stall_first", 32'(data_unstriped), 32'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_gap", 32'(valid_unstriped), 32'd0);
    end
    valid_stripe = 4'b0010;
    data_stripe = {8'h00, 8'h00, 8'h11, 8'h00};
    tick();
    idle(8);
    chk("stall_count", 32'(out_idx), 32'd16);

    // Backpressure: lane 0 also fills the output register, the others fill to DEPTH.
    for (int i = 0; i < L; i++) acc[i] = 0;
    ready_unstriped = 1'b0;
    for (int n = 0; n < 10; n++) begin
      valid_stripe = ready_stripe;
      data_stripe = $urandom;
      tick();
    end
    chk("bp_acc0", 32'(acc[0]), 32'(D + 1));
    for (int i = 1; i < L; i++) chk("bp_acc", 32'(acc[i]), 32'(D));
    chk("bp_ready_low", 32'(ready_stripe), 32'd0);
    ready_unstriped = 1'b1;
    idle(25);
    chk("bp_count", 32'(out_idx), 32'd16 + 32'(4*D + 1));

    // Overflow on lane 1 is sticky and the dropped word never appears.
    ready_unstriped = 1'b0;
    for (int n = 0; n < 12 && ready_stripe[1]; n++) begin
      valid_stripe = ready_stripe;
      data_stripe = $urandom;
      tick();
    end
    chk("ovf_lane1_full", 32'(ready_stripe[1]), 32'd0);
    valid_stripe = 4'b0010;
    data_stripe = {8'h00, 8'h00, 8'hEE, 8'h00};
    tick();
    chk("ovf_set", 32'(overflow_err), 32'h2);
    ready_unstriped = 1'b1;
    idle(30);
    chk("ovf_sticky", 32'(overflow_err), 32'h2);

    // Mid-stream reset discards buffered words; fresh stream restarts at lane 0.
    ready_unstriped = 1'b0;
    valid_stripe = 4'b0111;
    data_stripe = {8'h00, 8'h22, 8'h21, 8'h20};
    tick();
    valid_stripe = '0;
    reset_L = 1'b0;
    ready_unstriped = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_valid", 32'(valid_unstriped), 32'd0);
      chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
    end
    reset_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_quiet", 32'(valid_unstriped), 32'd0);
    end
    valid_stripe = '1;
    data_stripe = {8'h33, 8'h32, 8'h31, 8'h30};
    tick();
    valid_stripe = '0;
    tick();
    chk("restart_valid", 32'(valid_unstriped), 32'd1);
    chk("restart_first", 32'(data_unstriped), 32'h30);
    idle(8);
    chk("restart_count", 32'(out_idx), 32'd4);

    // Randomized traffic with occasional upstream violations of ready.
    for (int n = 0; n < 1500; n++) begin
      ready_unstriped = ($urandom_range(0, 3) != 0);
      vm = L'($urandom);
      if ($urandom_range(0, 19) != 0) vm = vm & ready_stripe;
      valid_stripe = vm;
      data_stripe = $urandom;
      tick();
    end
    ready_unstriped = 1'b1;
    idle(40);
    pending = 0;
    for (int i = 0; i < L; i++) pending += q[i].size();
    chk("drain_empty", 32'(pending), 32'd0);
    chk("drain_valid", 32'(valid_unstriped), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
